// File: rtl/log_readout_ctrl_pkg.sv
// Shared equalizer logging definitions.
// FSM encoding and word geometry for the log readout path.
package log_readout_ctrl_pkg;

   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_LATCH,
      ST_SEND,
      ST_FINISH
   } state_t;

endpackage

// File: rtl/log_readout_ctrl.sv
// Log readout controller: reads the log RAM word by word
// and streams each word MSB byte first to a UART transmitter.
import log_readout_ctrl_pkg::*;

module log_readout_ctrl #(
   parameter int RAM_WIDTH  = 32,
   parameter int ADDR_WIDTH = 15,
   parameter int NUM_WORDS  = 32000,
   parameter int RD_LATENCY = 1
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   output logic                  o_enbl_write,
   output logic                  o_enbl_read,
   output logic [ADDR_WIDTH-1:0] o_read_adrs,
   input  logic [RAM_WIDTH-1:0]  i_data_for_read,
   output logic [7:0]            o_tx_data,
   output logic                  o_tx_valid,
   input  logic                  i_tx_ready,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int WAIT_W = $clog2(RD_LATENCY + 1);

   localparam logic [WAIT_W-1:0] WAIT_LAST =
      WAIT_W'(RD_LATENCY - 1);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADRS =
      ADDR_WIDTH'(NUM_WORDS - 1);

   localparam logic [1:0] LAST_BYTE =
      2'(BYTES_PER_WORD - 1);

   state_t                state_q;
   state_t                state_d;
   logic [WAIT_W-1:0]     wait_cnt;
   logic [1:0]            byte_cnt;
   logic [ADDR_WIDTH-1:0] adrs_q;
   logic [RAM_WIDTH-1:0]  shift_q;

   logic byte_xfer;
   logic last_byte;
   logic last_word;
   logic wait_done;

   assign byte_xfer = (state_q == ST_SEND) && i_tx_ready;
   assign last_byte = (byte_cnt == LAST_BYTE);
   assign last_word = (adrs_q == LAST_ADRS);
   assign wait_done = (wait_cnt == WAIT_LAST);

   // State register.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode; i_start only matters in IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (i_start) state_d = ST_RD_REQ;
         end
         ST_RD_REQ: begin
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (wait_done) state_d = ST_LATCH;
         end
         ST_LATCH: begin
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (byte_xfer && last_byte) begin
               state_d = last_word ? ST_FINISH : ST_RD_REQ;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Address, counters and byte shift register.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         wait_cnt <= '0;
         byte_cnt <= '0;
         adrs_q   <= '0;
         shift_q  <= '0;
      end else begin
         unique case (state_q)
            ST_RD_REQ: begin
               wait_cnt <= '0;
               byte_cnt <= '0;
            end
            ST_RD_WAIT: begin
               if (!wait_done) begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ST_LATCH: begin
               shift_q <= i_data_for_read;
            end
            ST_SEND: begin
               if (byte_xfer) begin
                  shift_q  <= {shift_q[RAM_WIDTH-9:0], 8'h00};
                  byte_cnt <= byte_cnt + 2'd1;
                  if (last_byte && !last_word) begin
                     adrs_q <= adrs_q + ADDR_WIDTH'(1);
                  end
               end
            end
            ST_FINISH: begin
               adrs_q <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs are flops or straight decodes of the state flops.
   assign o_enbl_write = (state_q == ST_IDLE);
   assign o_enbl_read  = (state_q != ST_IDLE);
   assign o_busy       = (state_q != ST_IDLE);
   assign o_tx_valid   = (state_q == ST_SEND);
   assign o_done       = (state_q == ST_FINISH);
   assign o_read_adrs  = adrs_q;
   assign o_tx_data    = shift_q[RAM_WIDTH-1 -: 8];

endmodule

// File: doc/log_readout_ctrl.md
LOG_READOUT_CTRL -- requirements
Module: log_readout_ctrl

Interface
REQ-001 The block SHALL expose the following parameters, one per line as name, default, meaning:
  - RAM_WIDTH, 32, logged word width; fixed at 4 bytes.
  - ADDR_WIDTH, 15, RAM read address width.
  - NUM_WORDS, 32000, words read per dump.
  - RD_LATENCY, 1, RAM read latency in cycles: 1 for LOW_LATENCY, 2 for HIGH_PERFORMANCE.
REQ-002 The block SHALL expose the following ports, one per line as name, direction, width, meaning:
  - i_clock, in, 1, system clock.
  - i_reset, in, 1, synchronous active-high reset.
  - i_start, in, 1, single-cycle pulse that begins a dump.
  - o_enbl_write, out, 1, logging enable sent to the logger.
  - o_enbl_read, out, 1, RAM read enable sent to the logger.
  - o_read_adrs, out, ADDR_WIDTH, RAM read address.
  - i_data_for_read, in, RAM_WIDTH, RAM read data.
  - o_tx_data, out, 8, byte offered to the UART transmitter.
  - o_tx_valid, out, 1, o_tx_data is valid.
  - i_tx_ready, in, 1, transmitter accepts a byte.
  - o_busy, out, 1, a dump is in progress.
  - o_done, out, 1, one-cycle pulse at the end of a dump.

Function
REQ-003 The block SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, LATCH, SEND and FINISH.
REQ-004 In IDLE, the block SHALL hold o_enbl_write=1, o_enbl_read=0, o_busy=0, o_tx_valid=0 and o_read_adrs=0.
REQ-005 When i_start=1 in IDLE, the block SHALL go to RD_REQ on the next edge; i_start in any other state SHALL be ignored.
REQ-006 From RD_REQ to FINISH inclusive, the block SHALL hold o_enbl_write=0, o_enbl_read=1 and o_busy=1.
REQ-007 In RD_REQ, the block SHALL present the current address and enter RD_WAIT.
REQ-008 RD_WAIT SHALL last exactly RD_LATENCY cycles, counted by a wait counter; LATCH SHALL then capture i_data_for_read into a 32-bit shift register.
REQ-009 SEND SHALL output the bytes of the captured word MSB first: [31:24], [23:16], [15:8], [7:0].
REQ-010 In SEND, a byte SHALL transfer only on a cycle with o_tx_valid=1 and i_tx_ready=1; o_tx_valid SHALL be high throughout SEND.
REQ-011 o_tx_data SHALL remain stable while o_tx_valid=1 and i_tx_ready=0, with no timeout.
REQ-012 After the fourth byte transfers: if the address is below NUM_WORDS-1, the block SHALL increment the address and return to RD_REQ; otherwise it SHALL enter FINISH.
REQ-013 FINISH SHALL last one cycle, assert o_done=1, and return to IDLE with the address cleared to 0.
REQ-014 A full dump SHALL transfer exactly 4*NUM_WORDS bytes, with addresses 0..NUM_WORDS-1 each read exactly once and in order.
REQ-015 The address counter SHALL never exceed NUM_WORDS-1 and SHALL never wrap during a dump.
REQ-016 The minimum cycle count per word SHALL be 1 (RD_REQ) + RD_LATENCY + 1 (LATCH) + 4, assuming i_tx_ready is held at 1.
REQ-017 All outputs SHALL be registered, or decoded directly from registered state, with no combinational path from i_tx_ready to o_tx_valid.

Reset
REQ-018 When i_reset=1, on the next edge the block SHALL set state=IDLE, o_read_adrs=0, o_tx_data=0, o_tx_valid=0, o_done=0, o_busy=0, o_enbl_read=0, o_enbl_write=1, and clear the wait counter and byte counter.
REQ-019 A reset during any state SHALL abort the dump immediately; no partial byte SHALL be presented afterwards, and o_done SHALL NOT be pulsed.
REQ-020 After reset, a new i_start SHALL restart the dump from address 0.

Structure
REQ-021 The FSM state encoding and the BYTES_PER_WORD=4 constant SHALL reside in the shared equalizer logging package.
REQ-022 The block SHALL be a single module with no sub-modules; the RAM and the UART transmitter are external.
REQ-023 The byte counter SHALL be 2 bits wide, and the wait counter SHALL be $clog2(RD_LATENCY+1) bits wide.

Verification
REQ-024 The bench SHALL cover these directed scenarios, each as stimulus -> required response:
  - Reset, then idle -> o_enbl_write=1, o_busy=0, o_tx_valid=0.
  - NUM_WORDS=4 with RAM words 0x11223344, 0xA5A55A5A, 0x00000001, 0xFFFFFFFF, i_tx_ready=1, i_start pulse -> bytes 11,22,33,44,A5,A5,5A,5A,00,00,00,01,FF,FF,FF,FF; a single o_done pulse; 28 cycles from start to done for RD_LATENCY=1.
  - i_tx_ready=0 for 10 cycles during the second byte of word 0 -> o_tx_data=0x22 stable and no byte lost or repeated.
  - i_start pulsed again mid-dump -> no restart and no extra bytes, byte count still 16.
  - i_reset asserted while in SEND of word 2 -> o_tx_valid=0 on the next cycle, no o_done; a following i_start begins again at address 0.
  - RD_LATENCY=2 -> data captured 2 cycles after RD_REQ; byte stream identical to the second scenario.
